uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Controller and sequencer for the 16x-oversampled UART receive datapath (rx).
- Generates the oversampling tick and synchronises the rx pin for the receiver.
- Detects completed frames from the receiver's done flag, bit-orders the byte and buffers it in a small FIFO with a valid/ready output.
- Flags overrun, frame timeout and stop-bit (framing) errors; sits between the pad and the byte consumer.

Parameters:
- DIV_W, 16, width of the baud divisor.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- BIT_REVERSE, 1, 1 = reverse the receiver byte (it captures MSB-first) so m_data is standard LSB-first order.
- FRAME_TICKS, 168, tick budget from start-edge to done before a timeout error.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  enable; 0 holds tick generator and FSM idle
- baud_div  input  DIV_W  clk cycles per s_tick minus 1; latched while en=0
- rx_pin  input  1  asynchronous serial line
- rx_sync  output  1  2-flop-synchronised rx_pin, to receiver rx
- s_tick  output  1  oversample tick, one clk wide, to receiver s_tick
- rx_data  input  8  receiver out_data
- rx_done  input  1  receiver recieve_over (level; 1 = stop bit sampled high)
- m_data  output  8  FIFO head byte
- m_valid  output  1  FIFO non-empty
- m_ready  input  1  consumer accepts head when m_valid&m_ready
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
- overrun  output  1  sticky: byte dropped, FIFO full
- frame_err  output  1  sticky: timeout or stop bit low
- err_clr  input  1  clears sticky flags (1-cycle pulse)

Behaviour:
- Reset: rx_sync=1 (both sync flops preset to 1), s_tick=0, m_valid=0, fifo_count=0, overrun=0, frame_err=0, divisor register=0, FSM=IDLE, all pointers and counters 0.
- Tick generator: divisor register loads baud_div every cycle en=0. When en=1, a down-counter reloads from the register; s_tick=1 for the one cycle the counter reaches 0. A divisor of 0 gives s_tick every cycle.
- rx_done is edge-detected in clk with one history flop, reset 0.
- FSM states:
  - IDLE: entered when en=0. Goes to ARMED when en=1.
  - ARMED: waits for rx_sync falling edge, then FRAME with tick counter=0.
  - FRAME: counts s_tick. On rx_done rising, capture the byte, go to HOLD. If the count reaches FRAME_TICKS first, set frame_err and go to HOLD.
  - HOLD: waits for rx_sync=1 and rx_done=0 (or rx_done=1 stable with rx_sync=1 for 16 ticks), then ARMED.
  - en=0 in any state: immediate IDLE. The FIFO is kept. The tick counter stops and reloads.
- Stop-bit low: the receiver never raises rx_done, so the timeout path covers it.
- Capture: the byte is rx_data, bit-reversed if BIT_REVERSE=1, written the same cycle as the rx_done rise is seen. Latency from rx_done rise to m_valid: 1 clk when the FIFO was empty.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Write when full: byte dropped, overrun set, contents unchanged.
  - Simultaneous write and read when full: the pop frees a slot, so the write succeeds with no overrun and the count is unchanged.
  - Simultaneous write and read when empty: the write occurs, the read is ignored (m_valid was 0), count becomes 1.
  - m_data is the registered head, stable while m_valid=1 and m_ready=0.
- err_clr coinciding with a new error event: the set wins.
- Mid-frame reset: asynchronous return to reset values. A partial frame is discarded. The next start edge is detected only after rx_sync has been seen at 1.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, ARMED, FRAME, HOLD)
  - OVERSAMPLE=16
  - default divisor constants per baud/clock pair
  - the bit-reverse function
- One natural sub-module: uart_byte_fifo (parameterised depth, 8-bit, valid/ready pop, full/count, drop-on-full).
- The tick generator stays inline.

Test Plan:
- baud_div=3, en=1 → s_tick every 4th clk, exactly 1 cycle wide. Change baud_div while en=1 → period unchanged until en toggles.
- rx sends 0xA5 LSB-first at 16 ticks/bit (receiver in loop), m_ready=1 → m_data=0xA5 and m_valid for 1 clk, no errors.
- 5 back-to-back bytes 0x01..0x05 with m_ready=0, DEPTH=4 → fifo_count=4, overrun=1. Pops return 0x01..0x04 in order.
- Start bit followed by stop bit=0 → no byte written. frame_err=1 after FRAME_TICKS ticks. err_clr → frame_err=0. The next good frame is received normally.
- Write and pop in the same cycle with FIFO full → count stays 4, overrun stays 0. Same with FIFO empty → count becomes 1.
- rst asserted mid-frame (during bit 4) → all outputs return to reset values asynchronously. The following complete frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding, oversampling
// ratio, default baud divisors and the byte bit-reversal helper.
package uart_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t StIdle  = 2'd0;
    localparam rx_state_t StArmed = 2'd1;
    localparam rx_state_t StFrame = 2'd2;
    localparam rx_state_t StHold  = 2'd3;

    localparam int unsigned OVERSAMPLE = 16;

    // baud_div values (clk cycles per s_tick minus 1) for common clock/baud pairs
    localparam int unsigned DIV_50M_9600    = 50_000_000 / (9_600 * OVERSAMPLE) - 1;
    localparam int unsigned DIV_50M_115200  = 50_000_000 / (115_200 * OVERSAMPLE) - 1;
    localparam int unsigned DIV_100M_9600   = 100_000_000 / (9_600 * OVERSAMPLE) - 1;
    localparam int unsigned DIV_100M_115200 = 100_000_000 / (115_200 * OVERSAMPLE) - 1;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with valid/ready pop; a write into a full FIFO is dropped unless a pop
// frees a slot in the same cycle.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     wr_drop,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, push, pop;

    assign full     = (count_q == CW'(DEPTH));
    assign rd_valid = (count_q != '0);
    assign pop      = rd_ready && rd_valid;
    assign push     = wr_en && (!full || pop);
    assign wr_drop  = wr_en && full && !pop;
    assign rd_data  = mem_q[rptr_q];
    assign count    = count_q;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = wr_data;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer around a 16x-oversampled UART receiver: baud tick, rx synchroniser,
// frame supervision with timeout, byte capture into an output FIFO, sticky errors.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned BIT_REVERSE = 1,
    parameter int unsigned FRAME_TICKS = 168
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rx_pin,
    output logic                          rx_sync,
    output logic                          s_tick,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          err_clr
);

    localparam int unsigned CNT_MAX = (FRAME_TICKS > OVERSAMPLE) ? FRAME_TICKS : OVERSAMPLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] divcnt_q, divcnt_d;
    logic             tick_q, tick_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       vld_q, vld_d;
    logic             done_q, done_d;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             seen_q, seen_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    logic             done_rise;
    logic             wr_en;
    logic             ferr_set;
    logic             fifo_drop;
    logic [7:0]       wr_byte;

    assign rx_sync   = sync2_q;
    assign s_tick    = tick_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;
    assign done_rise = rx_done && !done_q;
    assign wr_byte   = (BIT_REVERSE != 0) ? bit_rev8(rx_data) : rx_data;

    // Tick generator: divisor is only sampled while disabled.
    always_comb begin
        div_d    = div_q;
        divcnt_d = divcnt_q;
        tick_d   = 1'b0;
        if (!en) begin
            div_d    = baud_div;
            divcnt_d = baud_div;
        end else if (divcnt_q == '0) begin
            divcnt_d = div_q;
            tick_d   = 1'b1;
        end else begin
            divcnt_d = divcnt_q - DIV_W'(1);
        end
    end

    always_comb begin
        sync1_d = rx_pin;
        sync2_d = sync1_q;
        vld_d   = {vld_q[0], 1'b1};
        done_d  = rx_done;
    end

    // seen_q: line observed idle-high through a settled synchroniser before a start edge
    // is accepted, so reset presets and partial frames never look like a start bit.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        seen_d   = 1'b0;
        wr_en    = 1'b0;
        ferr_set = 1'b0;
        if (!en) begin
            state_d = StIdle;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StArmed;
                end
                StArmed: begin
                    seen_d = seen_q || (vld_q[1] && sync2_q);
                    if (seen_q && !sync2_q) begin
                        state_d = StFrame;
                        tcnt_d  = '0;
                        seen_d  = 1'b0;
                    end
                end
                StFrame: begin
                    if (done_rise) begin
                        wr_en   = 1'b1;
                        state_d = StHold;
                        tcnt_d  = '0;
                    end else if (tick_q) begin
                        if (tcnt_q == CNT_W'(FRAME_TICKS - 1)) begin
                            ferr_set = 1'b1;
                            state_d  = StHold;
                            tcnt_d   = '0;
                        end else begin
                            tcnt_d = tcnt_q + CNT_W'(1);
                        end
                    end
                end
                StHold: begin
                    if (sync2_q && !rx_done) begin
                        state_d = StArmed;
                        tcnt_d  = '0;
                    end else if (sync2_q) begin
                        if (tick_q) begin
                            if (tcnt_q == CNT_W'(OVERSAMPLE - 1)) begin
                                state_d = StArmed;
                                tcnt_d  = '0;
                            end else begin
                                tcnt_d = tcnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        tcnt_d = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    // A new error event wins over a coincident clear.
    always_comb begin
        ovr_d  = fifo_drop || (ovr_q && !err_clr);
        ferr_d = ferr_set || (ferr_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            divcnt_q <= '0;
            tick_q   <= 1'b0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            vld_q    <= '0;
            done_q   <= 1'b0;
            state_q  <= StIdle;
            tcnt_q   <= '0;
            seen_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            divcnt_q <= divcnt_d;
            tick_q   <= tick_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            seen_q   <= seen_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_byte),
        .wr_drop  (fifo_drop),
        .rd_data  (m_data),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural MSB-first receiver in the loop
// and a byte scoreboard checked whenever the consumer pops the FIFO.
module tb_uart_rx_ctrl;

    localparam int unsigned DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en;
    logic [DIV_W-1:0] baud_div;
    logic             rx_pin;
    logic             rx_sync;
    logic             s_tick;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_done = 1'b0;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic [2:0]       fifo_count;
    logic             overrun;
    logic             frame_err;
    logic             err_clr;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .baud_div   (baud_div),
        .rx_pin     (rx_pin),
        .rx_sync    (rx_sync),
        .s_tick     (s_tick),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
    );

    // Receiver stand-in: samples mid-bit on s_tick, shifts MSB-first, holds done high.
    int         r_st = 0;
    int         r_tk = 0;
    int         r_bit = 0;
    logic [7:0] r_sh = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st    <= 0;
            r_tk    <= 0;
            r_bit   <= 0;
            r_sh    <= 8'h00;
            rx_done <= 1'b0;
            rx_data <= 8'h00;
        end else if (s_tick) begin
            case (r_st)
                0: if (!rx_sync) begin
                    r_st    <= 1;
                    r_tk    <= 1;
                    rx_done <= 1'b0;
                end
                1: if (r_tk == 8) begin
                    r_st  <= 2;
                    r_tk  <= 1;
                    r_bit <= 0;
                end else r_tk <= r_tk + 1;
                2: if (r_tk == 16) begin
                    r_sh <= {r_sh[6:0], rx_sync};
                    r_tk <= 1;
                    if (r_bit == 7) r_st <= 3;
                    else r_bit <= r_bit + 1;
                end else r_tk <= r_tk + 1;
                3: if (r_tk == 16) begin
                    if (rx_sync) begin
                        rx_data <= r_sh;
                        rx_done <= 1'b1;
                        r_st    <= 0;
                    end else r_st <= 4;
                end else r_tk <= r_tk + 1;
                default: if (rx_sync) r_st <= 0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer-side scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            pops++;
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pulse=1 raises m_ready for exactly the cycle the done rise is seen.
    task automatic wait_ticks(input int n, input bit pulse);
        int   got = 0;
        int   guard = 0;
        logic prev = rx_done;
        while (got < n && guard < 20000) begin
            step();
            guard++;
            if (pulse) m_ready = rx_done && !prev;
            prev = rx_done;
            if (s_tick) got++;
        end
        if (pulse) m_ready = 1'b0;
        if (guard >= 20000) chk("tick_wait_bound", 32'(got), 32'(n));
    endtask

    task automatic tick_gap(output int gap);
        int g = 0;
        while (!s_tick && g < 1000) begin
            step();
            g++;
        end
        step();
        gap = 1;
        while (!s_tick && gap < 1000) begin
            step();
            gap++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pulse);
        rx_pin = 1'b0;
        wait_ticks(16, 0);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            wait_ticks(16, 0);
        end
        rx_pin = stop;
        wait_ticks(16, pulse);
    endtask

    task automatic idle_tail();
        rx_pin = 1'b1;
        wait_ticks(16, 0);
    endtask

    task automatic good_frame(input logic [7:0] b, input bit pulse);
        exp_q.push_back(b);
        send_frame(b, 1'b1, pulse);
        idle_tail();
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        step();
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        int         gap;
        int         p0;
        logic [7:0] part;

        en       = 1'b0;
        baud_div = 16'd3;
        rx_pin   = 1'b1;
        m_ready  = 1'b0;
        err_clr  = 1'b0;
        step();
        step();
        chk("rst_rx_sync", 32'(rx_sync), 32'd1);
        chk("rst_s_tick", 32'(s_tick), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        step();
        step();

        // Tick period follows the latched divisor only.
        en = 1'b1;
        tick_gap(gap);
        chk("tick_period_div3", 32'(gap), 32'd4);
        baud_div = 16'd7;
        tick_gap(gap);
        chk("tick_period_hold", 32'(gap), 32'd4);
        en = 1'b0;
        step();
        en = 1'b1;
        tick_gap(gap);
        chk("tick_period_div7", 32'(gap), 32'd8);
        en       = 1'b0;
        baud_div = 16'd3;
        step();
        en = 1'b1;
        repeat (8) step();

        // Single byte straight through to the consumer.
        m_ready = 1'b1;
        p0 = pops;
        good_frame(8'hA5, 0);
        chk("a5_pop_count", 32'(pops - p0), 32'd1);
        chk("a5_m_valid", 32'(m_valid), 32'd0);
        chk("a5_overrun", 32'(overrun), 32'd0);
        chk("a5_frame_err", 32'(frame_err), 32'd0);

        // Five bytes into a four-entry FIFO with no consumer.
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) good_frame(8'(i), 0);
        send_frame(8'h05, 1'b1, 0);
        idle_tail();
        chk("ovr_count", 32'(fifo_count), 32'd4);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_head", 32'(m_data), 32'h01);
        repeat (5) step();
        chk("ovr_head_stable", 32'(m_data), 32'h01);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        drain("ovr_drain");
        m_ready = 1'b0;

        // Stop bit low: nothing written, timeout raises frame_err.
        send_frame(8'h5A, 1'b0, 0);
        chk("ferr_before_budget", 32'(frame_err), 32'd0);
        idle_tail();
        chk("ferr_after_budget", 32'(frame_err), 32'd1);
        chk("ferr_no_write", 32'(fifo_count), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ferr_cleared", 32'(frame_err), 32'd0);
        m_ready = 1'b1;
        good_frame(8'h77, 0);
        chk("ferr_recover_sb", 32'(exp_q.size()), 32'd0);
        chk("ferr_recover_flag", 32'(frame_err), 32'd0);

        // Write and pop in the same cycle with the FIFO full.
        m_ready = 1'b0;
        good_frame(8'h11, 0);
        good_frame(8'h22, 0);
        good_frame(8'h33, 0);
        good_frame(8'h44, 0);
        chk("full_count_pre", 32'(fifo_count), 32'd4);
        good_frame(8'h55, 1);
        chk("full_simul_count", 32'(fifo_count), 32'd4);
        chk("full_simul_overrun", 32'(overrun), 32'd0);
        chk("full_simul_head", 32'(m_data), 32'h22);
        drain("full_drain");
        m_ready = 1'b0;

        // Write and pop-request in the same cycle with the FIFO empty.
        good_frame(8'h66, 1);
        chk("empty_simul_count", 32'(fifo_count), 32'd1);
        chk("empty_simul_head", 32'(m_data), 32'h66);

        // Asynchronous reset during data bit 4.
        part   = 8'h3C;
        rx_pin = 1'b0;
        wait_ticks(16, 0);
        for (int i = 0; i < 4; i++) begin
            rx_pin = part[i];
            wait_ticks(16, 0);
        end
        rx_pin = part[4];
        wait_ticks(8, 0);
        #1;
        rst    = 1'b1;
        rx_pin = 1'b1;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_rx_sync", 32'(rx_sync), 32'd1);
        chk("arst_s_tick", 32'(s_tick), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_frame_err", 32'(frame_err), 32'd0);
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        en  = 1'b0;
        step();
        step();
        en = 1'b1;
        repeat (8) step();
        m_ready = 1'b1;
        good_frame(8'h3C, 0);
        chk("post_rst_sb", 32'(exp_q.size()), 32'd0);
        chk("post_rst_frame_err", 32'(frame_err), 32'd0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
